mux4_rr_arbiter: RTL and testbench



---
 rtl/mux4_rr_arbiter.sv | 126 ++++++++++++
 tb/tb_mux4_rr_arbiter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/mux4_rr_arbiter.sv
// Purpose : round-robin burst arbiter sharing one 32-bit 4:1 mux channel between four requesters.
// Latency : req -> grant/sel one cycle; a release always costs one idle bubble cycle before the next grant.
// Backpres: out_ready=0 holds the current owner indefinitely with no beat counted.
//
// Ports:
//   Clk, Reset    rising-edge clock, synchronous active-high reset
//   req[3:0]      requester i has a valid beat on mux input i
//   out_ready     downstream accepts the beat this cycle
//   grant[3:0]    registered one-hot owner, zero when idle
//   sel[1:0]      registered mux select, index of the grant bit (held while idle)
//   out_valid     owner currently presents a beat
//   ack[3:0]      one-hot beat-accepted pulse to the owner
//   busy          registered, high while a grant is held
module mux4_rr_arbiter #(
  parameter int MAX_BURST = 4,
  parameter int CNT_W     = 8
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [3:0] req,
  input  logic       out_ready,
  output logic [3:0] grant,
  output logic [1:0] sel,
  output logic       out_valid,
  output logic [3:0] ack,
  output logic       busy
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_GRANT = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [3:0]       grant_q, grant_d;
  logic [1:0]       sel_q, sel_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [1:0]       ptr_q, ptr_d;

  logic             win_vld;
  logic [1:0]       win_idx;
  logic [1:0]       cand;
  logic             beat;
  logic             last_beat;

  // A beat moves only when the owner has data and the consumer takes it.
  assign beat      = (|(grant_q & req)) & out_ready;
  assign last_beat = beat && ((count_q + CNT_W'(1)) == CNT_W'(MAX_BURST));

  assign grant     = grant_q;
  assign sel       = sel_q;
  assign busy      = busy_q;
  assign out_valid = |(grant_q & req);
  // The edge that samples Reset discards any in-flight beat, so no ack is shown for it.
  assign ack       = (grant_q & req & {4{out_ready}}) & {4{~Reset}};

  // First requester found searching upward from ptr, wrapping 3 -> 0.
  always_comb begin
    win_vld = 1'b0;
    win_idx = ptr_q;
    cand    = '0;
    for (int k = 0; k < 4; k++) begin
      cand = ptr_q + 2'(k);
      if (!win_vld && req[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    sel_d   = sel_q;
    busy_d  = busy_q;
    count_d = count_q;
    ptr_d   = ptr_q;
    case (state_q)
      S_IDLE: begin
        if (win_vld) begin
          grant_d = 4'b0001 << win_idx;
          sel_d   = win_idx;
          count_d = '0;
          busy_d  = 1'b1;
          state_d = S_GRANT;
        end
      end
      S_GRANT: begin
        // Release on burst exhaustion or owner withdrawal; sel is left alone.
        if (!req[sel_q] || last_beat) begin
          grant_d = '0;
          busy_d  = 1'b0;
          count_d = '0;
          ptr_d   = sel_q + 2'd1;
          state_d = S_IDLE;
        end else if (beat) begin
          count_d = count_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
        busy_d  = 1'b0;
        count_d = '0;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      sel_q   <= 2'b00;
      busy_q  <= 1'b0;
      count_q <= '0;
      ptr_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      sel_q   <= sel_d;
      busy_q  <= busy_d;
      count_q <= count_d;
      ptr_q   <= ptr_d;
    end
  end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Bench for mux4_rr_arbiter (MAX_BURST=4): per-cycle expected outputs are queued with the
// stimulus, then each cycle is driven after a falling edge and compared before the next rising edge.
module tb_mux4_rr_arbiter;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic [3:0] req = 4'b0000;
  logic       out_ready = 1'b0;
  logic [3:0] grant;
  logic [1:0] sel;
  logic       out_valid;
  logic [3:0] ack;
  logic       busy;

  mux4_rr_arbiter #(.MAX_BURST(4), .CNT_W(8)) dut (
    .Clk(Clk), .Reset(Reset), .req(req), .out_ready(out_ready),
    .grant(grant), .sel(sel), .out_valid(out_valid), .ack(ack), .busy(busy)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [3:0] grant;
    logic [1:0] sel;
    logic       ov;
    logic [3:0] ack;
    logic       busy;
  } exp_t;

  typedef struct packed {
    logic       rst;
    logic [3:0] req;
    logic       rdy;
  } stim_t;

  stim_t stim_q[$];
  exp_t  exp_q[$];
  int    vectors = 0;
  int    errors  = 0;

  task automatic drive(input logic r, input logic [3:0] q, input logic rd);
    @(negedge Clk);
    Reset = r; req = q; out_ready = rd;
    #1;
  endtask

  task automatic push(input logic r, input logic [3:0] q, input logic rd,
                      input logic [3:0] g, input logic [1:0] s, input logic ov,
                      input logic [3:0] a, input logic b);
    stim_q.push_back('{rst: r, req: q, rdy: rd});
    exp_q.push_back('{grant: g, sel: s, ov: ov, ack: a, busy: b});
  endtask

  task automatic push_idle(input logic [3:0] q, input logic [1:0] s);
    push(1'b0, q, 1'b1, 4'b0000, s, 1'b0, 4'b0000, 1'b0);
  endtask

  task automatic push_beat(input logic [3:0] q, input int o);
    push(1'b0, q, 1'b1, 4'(1 << o), 2'(o), 1'b1, 4'(1 << o), 1'b1);
  endtask

  task automatic do_reset();
    drive(1'b1, 4'b0000, 1'b0);
    drive(1'b1, 4'b0000, 1'b0);
  endtask

  task automatic test_reset();
    stim_t s; exp_t e; exp_t o;
    drive(1'b1, 4'b1111, 1'b1);  // registers not yet reset
    push(1'b1, 4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0, 4'b0000, 1'b0);
    push_idle(4'b1111, 2'd0);
    push_beat(4'b1111, 0);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      drive(s.rst, s.req, s.rdy);
      e = exp_q.pop_front();
      o = '{grant: grant, sel: sel, ov: out_valid, ack: ack, busy: busy};
      vectors++;
      if (o !== e) begin
        errors++;
        $display("FAIL reset: got %h required %h", o, e);
      end
    end
  endtask

  task automatic test_rotation();
    stim_t s; exp_t e; exp_t o;
    do_reset();
    push_idle(4'b1111, 2'd0);
    for (int ow = 0; ow < 4; ow++) begin
      for (int b = 0; b < 4; b++) push_beat(4'b1111, ow);
      push_idle(4'b1111, 2'(ow));
    end
    push_beat(4'b1111, 0);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      drive(s.rst, s.req, s.rdy);
      e = exp_q.pop_front();
      o = '{grant: grant, sel: sel, ov: out_valid, ack: ack, busy: busy};
      vectors++;
      if (o !== e) begin
        errors++;
        $display("FAIL rotation: got %h required %h", o, e);
      end
    end
  endtask

  task automatic test_backpressure();
    stim_t s; exp_t e; exp_t o;
    do_reset();
    push(1'b0, 4'b0100, 1'b0, 4'b0000, 2'd0, 1'b0, 4'b0000, 1'b0);
    for (int i = 0; i < 5; i++)
      push(1'b0, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 4'b0000, 1'b1);
    // Exactly four acks after the stall proves the count did not move.
    for (int i = 0; i < 4; i++) push_beat(4'b0100, 2);
    push_idle(4'b0100, 2'd2);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      drive(s.rst, s.req, s.rdy);
      e = exp_q.pop_front();
      o = '{grant: grant, sel: sel, ov: out_valid, ack: ack, busy: busy};
      vectors++;
      if (o !== e) begin
        errors++;
        $display("FAIL backpressure: got %h required %h", o, e);
      end
    end
  endtask

  task automatic test_withdraw();
    stim_t s; exp_t e; exp_t o;
    do_reset();
    push_idle(4'b0110, 2'd0);
    push_beat(4'b0110, 1);
    push_beat(4'b0110, 1);
    // req[0] also set: only ptr=2 makes requester 2 the winner.
    push(1'b0, 4'b0101, 1'b1, 4'b0010, 2'd1, 1'b0, 4'b0000, 1'b1);
    push_idle(4'b0101, 2'd1);
    push_beat(4'b0101, 2);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      drive(s.rst, s.req, s.rdy);
      e = exp_q.pop_front();
      o = '{grant: grant, sel: sel, ov: out_valid, ack: ack, busy: busy};
      vectors++;
      if (o !== e) begin
        errors++;
        $display("FAIL withdraw: got %h required %h", o, e);
      end
    end
  endtask

  task automatic test_wrap();
    stim_t s; exp_t e; exp_t o;
    do_reset();
    push_idle(4'b1000, 2'd0);
    for (int i = 0; i < 4; i++) push_beat(4'b1000, 3);
    push_idle(4'b1001, 2'd3);
    push_beat(4'b1001, 0);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      drive(s.rst, s.req, s.rdy);
      e = exp_q.pop_front();
      o = '{grant: grant, sel: sel, ov: out_valid, ack: ack, busy: busy};
      vectors++;
      if (o !== e) begin
        errors++;
        $display("FAIL wrap: got %h required %h", o, e);
      end
    end
  endtask

  task automatic test_midburst_reset();
    stim_t s; exp_t e; exp_t o;
    do_reset();
    push_idle(4'b1111, 2'd0);
    for (int ow = 0; ow < 2; ow++) begin
      for (int b = 0; b < 4; b++) push_beat(4'b1111, ow);
      push_idle(4'b1111, 2'(ow));
    end
    push_beat(4'b1111, 2);
    push_beat(4'b1111, 2);
    push(1'b1, 4'b1111, 1'b1, 4'b0100, 2'd2, 1'b1, 4'b0000, 1'b1);
    push_idle(4'b0110, 2'd0);
    push_beat(4'b0110, 1);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      drive(s.rst, s.req, s.rdy);
      e = exp_q.pop_front();
      o = '{grant: grant, sel: sel, ov: out_valid, ack: ack, busy: busy};
      vectors++;
      if (o !== e) begin
        errors++;
        $display("FAIL midburst_reset: got %h required %h", o, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_rotation();
    test_backpressure();
    test_withdraw();
    test_wrap();
    test_midburst_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
